// File: rtl/enum_token_source_pkg.sv
// Shared token enumeration and its wrap-around successor, used by the token source
// and by the downstream wildcard-import checker.
package p;

  typedef enum int {
    A = 1,
    B = 2,
    C = 3
  } test_enum;

  // Successor in the A->B->C->A cycle; any unknown encoding recovers to A.
  function automatic test_enum next_token(test_enum t);
    case (t)
      A:       return B;
      B:       return C;
      C:       return A;
      default: return A;
    endcase
  endfunction

endpackage

// File: rtl/enum_token_source_if.sv
// Valid/ready token stream between the token source and its consumer.
interface enum_token_source_if #(
  parameter int unsigned W_IDX = 8
);

  logic             out_valid;
  logic             out_ready;
  p::test_enum      out_token;
  logic [W_IDX-1:0] out_index;

  modport master (
    output out_valid,
    output out_token,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_token,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/enum_token_source_ctr.sv
// Token/index registers of the burst: clear restarts at (p::A, 0), advance steps both.
module enum_token_ctr
  import p::*;
#(
  parameter int unsigned W_IDX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output test_enum         token,
  output logic [W_IDX-1:0] index
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      token <= p::A;
      index <= '0;
    end else if (clear) begin
      token <= p::A;
      index <= '0;
    end else if (advance) begin
      token <= next_token(token);
      index <= index + W_IDX'(1);
    end
  end

endmodule

// File: rtl/enum_token_source.sv
// Burst token source: on start, streams A tokens (p::A, p::B, p::C, ...) then pulses done.
// The local parameter A intentionally hides the imported enum literal; the literal is always p::A.
module enum_token_source #(
  parameter int unsigned A     = 10,
  parameter int unsigned W_IDX = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  enum_token_source_if.master  bus,
  output logic                 busy,
  output logic                 done
);

  import p::*;

  if (64'(A) > (64'd1 << W_IDX)) begin : g_bad_range
    $error("enum_token_source: A=%0d does not fit in W_IDX=%0d index bits", A, W_IDX);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } src_state_e;

  localparam logic [W_IDX-1:0] LAST_IDX = (A == 0) ? '0 : W_IDX'(A - 1);

  src_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic             xfer;
  logic             clear;
  logic             advance;
  test_enum         token;
  logic [W_IDX-1:0] index;

  enum_token_ctr #(.W_IDX(W_IDX)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .advance (advance),
    .token   (token),
    .index   (index)
  );

  assign bus.out_valid = valid_q;
  assign bus.out_token = token;
  assign bus.out_index = index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Last token clears the counter so the index never leaves 0..A-1.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    clear   = 1'b0;
    advance = 1'b0;
    xfer    = valid_q & bus.out_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear = 1'b1;
          if (A == 0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          if (index == LAST_IDX) begin
            clear   = 1'b1;
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule
